// File: rtl/syscall_sequencer.sv
// syscall_sequencer: multi-cycle console service engine (print_int, print_string, print_char, exit) for the MIPS core.
// Ports:
//   clock_i        core clock, rising edge
//   reset_ni       asynchronous active-low reset
//   syscall_en_i   current instruction is SYSCALL
//   v0_i, a0_i     service code and argument
//   mem_addr_o     word-aligned data-memory read address
//   mem_rd_o       read strobe; mem_rdata_i is valid the cycle after
//   mem_rdata_i    data-memory read word
//   char_out_o     output character, char_valid_o / char_ready_i handshake
//   stall_o        hold PC (combinational)
//   halt_o         exit executed, sticky until reset
//   error_o        unsupported code or string too long, sticky until reset
// Build option: define SYSCALL_NEWLINE_EN to append 0x0A after print_int digits.
module syscall_sequencer #(
  parameter int MAX_STR = 256,
  parameter int NDIG    = 10
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        syscall_en_i,
  input  logic [31:0] v0_i,
  input  logic [31:0] a0_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [31:0] mem_rdata_i,
  output logic [7:0]  char_out_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic        stall_o,
  output logic        halt_o,
  output logic        error_o
);
  localparam int DW = $clog2(NDIG);
  localparam int CW = $clog2(NDIG + 4);
  localparam int SW = $clog2(MAX_STR + 1);
`ifdef SYSCALL_NEWLINE_EN
  localparam logic [CW-1:0] NL = CW'(1);
`else
  localparam logic [CW-1:0] NL = '0;
`endif

  typedef enum logic [3:0] {
    IDLE, INT_CONV, INT_EMIT, STR_FETCH, STR_WAIT, STR_EMIT, CHAR_EMIT, DONE, HALTED
  } state_t;

  state_t        state_q;
  logic [31:0]   mag_q, ptr_q, mem_addr_q;
  logic [3:0]    dig_q [NDIG];
  logic [CW-1:0] ndig_q, rem_q;
  logic [SW-1:0] cnt_q;
  logic          neg_q, char_valid_q, mem_rd_q, halt_q, error_q;
  logic [7:0]    char_q;
  logic [31:0]   mag_div, ptr_inc;
  logic [3:0]    mag_rem;
  logic [7:0]    str_byte;

  always_comb begin
    mag_div  = mag_q / 32'd10;
    mag_rem  = 4'(mag_q - mag_div * 32'd10);
    ptr_inc  = ptr_q + 32'd1;
    str_byte = mem_rdata_i[{ptr_q[1:0], 3'b000} +: 8];
  end

  // r counts characters still to send, including the one being produced:
  // the newline (if enabled) is r==1, the digits sit above it with the least
  // significant digit lowest, and the sign is the single slot above the digits.
  function automatic logic [7:0] int_char(input logic [CW-1:0] r);
    logic [CW-1:0] k;
    k = r - NL - CW'(1);
    if (NL != '0 && r == CW'(1)) int_char = 8'h0A;
    else if (r > ndig_q + NL)    int_char = 8'h2D;
    else                         int_char = 8'h30 + {4'h0, dig_q[k[DW-1:0]]};
  endfunction

  always_ff @(posedge clock_i)
    if (state_q == INT_CONV) dig_q[ndig_q[DW-1:0]] <= mag_rem;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      mag_q        <= '0;
      ptr_q        <= '0;
      mem_addr_q   <= '0;
      ndig_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      char_valid_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      halt_q       <= 1'b0;
      error_q      <= 1'b0;
      char_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (syscall_en_i) begin
          case (v0_i)
            32'd1: begin
              state_q <= INT_CONV;
              neg_q   <= a0_i[31];
              mag_q   <= a0_i[31] ? 32'd0 - a0_i : a0_i;
              ndig_q  <= '0;
            end
            32'd4: begin
              state_q    <= STR_FETCH;
              ptr_q      <= a0_i;
              cnt_q      <= '0;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= {a0_i[31:2], 2'b00};
            end
            32'd11: begin
              state_q <= CHAR_EMIT;
              char_q  <= a0_i[7:0];
            end
            32'd10: begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end
            default: begin
              state_q <= DONE;
              error_q <= 1'b1;
            end
          endcase
        end
        INT_CONV: begin
          mag_q  <= mag_div;
          ndig_q <= ndig_q + CW'(1);
          if (mag_div == '0) begin
            state_q <= INT_EMIT;
            rem_q   <= ndig_q + CW'(1) + CW'(neg_q) + NL;
          end
        end
        // Accepting a character loads the next one in the same edge, so a
        // ready sink sees one character per cycle.
        INT_EMIT: begin
          if (!char_valid_q) begin
            char_q       <= int_char(rem_q);
            char_valid_q <= 1'b1;
          end else if (char_ready_i) begin
            if (rem_q == CW'(1)) begin
              char_valid_q <= 1'b0;
              state_q      <= DONE;
            end else begin
              char_q <= int_char(rem_q - CW'(1));
              rem_q  <= rem_q - CW'(1);
            end
          end
        end
        STR_FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= STR_WAIT;
        end
        STR_WAIT: begin
          if (str_byte == 8'h00) state_q <= DONE;
          else if (cnt_q == SW'(MAX_STR)) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end else begin
            char_q  <= str_byte;
            state_q <= STR_EMIT;
          end
        end
        STR_EMIT: begin
          if (!char_valid_q) char_valid_q <= 1'b1;
          else if (char_ready_i) begin
            char_valid_q <= 1'b0;
            ptr_q        <= ptr_inc;
            cnt_q        <= cnt_q + SW'(1);
            mem_rd_q     <= 1'b1;
            mem_addr_q   <= {ptr_inc[31:2], 2'b00};
            state_q      <= STR_FETCH;
          end
        end
        CHAR_EMIT: begin
          if (!char_valid_q) char_valid_q <= 1'b1;
          else if (char_ready_i) begin
            char_valid_q <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o      = (syscall_en_i & (state_q != DONE)) | (state_q == HALTED);
  assign mem_addr_o   = mem_addr_q;
  assign mem_rd_o     = mem_rd_q;
  assign char_out_o   = char_q;
  assign char_valid_o = char_valid_q;
  assign halt_o       = halt_q;
  assign error_o      = error_q;
endmodule

// File: tb/tb_syscall_sequencer.sv
// tb_syscall_sequencer: randomized self-checking bench for syscall_sequencer against a behavioural console model.
module tb_syscall_sequencer;
  localparam int TB_MAX = 16;

  logic        clock = 1'b0, reset_n = 1'b1, syscall_en = 1'b0, char_ready = 1'b0;
  logic [31:0] v0 = '0, a0 = '0, mem_rdata = '0;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o, char_valid_o, stall_o, halt_o, error_o;
  logic [7:0]  char_out_o;

  syscall_sequencer #(.MAX_STR(TB_MAX)) dut (
    .clock_i(clock), .reset_ni(reset_n), .syscall_en_i(syscall_en), .v0_i(v0), .a0_i(a0),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata),
    .char_out_o(char_out_o), .char_valid_o(char_valid_o), .char_ready_i(char_ready),
    .stall_o(stall_o), .halt_o(halt_o), .error_o(error_o)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_bad = 0, vcycles = 0, rmode = 1;
  logic        mon_en = 1'b0, hold = 1'b0, err_exp = 1'b0;
  logic [7:0]  held_char;
  logic [7:0]  mem [4096];
  logic [7:0]  got_q[$], exp_q[$];
  logic [31:0] rd_got[$], rd_exp[$];
  logic        pat[$];

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] ad);
    logic [11:0] b;
    b = ad[11:0];
    word = {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
  endfunction

  // Sink, stability checker and memory responder, all away from the active edge.
  always @(negedge clock) begin
    if (mon_en) begin
      if (rmode == 0) char_ready = 1'($urandom_range(0, 1));
      else if (rmode == 1) char_ready = 1'b1;
      else char_ready = char_valid_o && pat.size() > 0 ? pat.pop_front() : 1'b0;
      if (hold) begin
        chk("hold_valid", 32'(char_valid_o), 32'd1);
        chk("hold_char", 32'(char_out_o), 32'(held_char));
      end
      hold = char_valid_o && !char_ready;
      held_char = char_out_o;
      if (char_valid_o) vcycles++;
      if (char_valid_o && char_ready) got_q.push_back(char_out_o);
      if (mem_rd_o) begin
        mem_rdata = word(mem_addr_o);
        rd_got.push_back(mem_addr_o);
      end
    end
  end

  task automatic model(input logic [31:0] v, input logic [31:0] a);
    string       s;
    logic [31:0] ad;
    logic [7:0]  b;
    case (v)
      32'd1: begin
        s = $sformatf("%0d", $signed(a));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef SYSCALL_NEWLINE_EN
        exp_q.push_back(8'h0A);
`endif
      end
      32'd4: for (int k = 0; k <= TB_MAX; k++) begin
        ad = a + 32'(k);
        b = mem[ad[11:0]];
        rd_exp.push_back({ad[31:2], 2'b00});
        if (b == 8'h00) break;
        if (k == TB_MAX) begin
          err_exp = 1'b1;
          break;
        end
        exp_q.push_back(b);
      end
      32'd11: exp_q.push_back(a[7:0]);
      default: err_exp = 1'b1;
    endcase
  endtask

  task automatic run(input logic [31:0] v, input logic [31:0] a);
    int n = 0;
    model(v, a);
    syscall_en = 1'b1;
    v0 = v;
    a0 = a;
    do begin
      @(negedge clock);
      n++;
    end while (stall_o && n < 3000);
    if (stall_o) chk("service_timeout", 32'd1, 32'd0);
  endtask

  task automatic verify(input string tag);
    syscall_en = 1'b0;
    chk({tag, ":nchar"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ":char"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, ":nread"}, 32'(rd_got.size()), 32'(rd_exp.size()));
    for (int i = 0; i < rd_exp.size() && i < rd_got.size(); i++)
      chk({tag, ":raddr"}, rd_got[i], rd_exp[i]);
    chk({tag, ":error"}, 32'(error_o), 32'(err_exp));
    chk({tag, ":halt"}, 32'(halt_o), 32'd0);
    got_q.delete();
    exp_q.delete();
    rd_got.delete();
    rd_exp.delete();
  endtask

  task automatic do_reset();
    #2;
    mon_en = 1'b0;
    hold = 1'b0;
    syscall_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(char_valid_o), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd_o), 32'd0);
    chk("rst_halt", 32'(halt_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_char", 32'(char_out_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    rd_got.delete();
    rd_exp.delete();
    err_exp = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, a;
    int          len;
    logic        chain;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    @(negedge clock);
    do_reset();
    rmode = 1;
    run(32'd1, -32'sd305);      verify("int_m305");
    run(32'd1, 32'h80000000);   verify("int_min");
    run(32'd1, 32'd0);          verify("int_zero");
    mem[12'h001] = "H"; mem[12'h002] = "i"; mem[12'h003] = 8'h00;
    mem[12'h004] = "x";
    rmode = 0;
    run(32'd4, 32'h00001001);   verify("str_hi");
    mem[12'hFFE] = "a"; mem[12'hFFF] = "b"; mem[12'h000] = "c"; mem[12'h001] = 8'h00;
    run(32'd4, 32'hFFFFFFFE);   verify("str_wrap");
    rmode = 2;
    pat = '{1'b0, 1'b0, 1'b1};
    vcycles = 0;
    run(32'd11, 32'h00000141);  verify("char_A");
    chk("char_A_valid_cycles", 32'(vcycles), 32'd3);
    rmode = 0;
    run(32'd11, 32'h5A);
    run(32'd1, 32'd42);
    run(32'd11, 32'h0);         verify("back2back");
    for (int j = 0; j < 20; j++) mem[12'h200 + 12'(j)] = 8'h61 + 8'(j);
    mem[12'h214] = 8'h00;
    run(32'd4, 32'h00000200);   verify("str_overflow");
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rmode = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          v = 32'd1;
          case ($urandom_range(0, 3))
            0: a = $urandom;
            1: a = 32'($urandom_range(0, 200)) - 32'd100;
            2: a = 32'h7FFFFFFF;
            default: a = 32'h80000000 | 32'($urandom_range(0, 9));
          endcase
        end
        4, 5, 6: begin
          v = 32'd4;
          a = $urandom;
          len = $urandom_range(0, 19);
          for (int j = 0; j < len; j++) mem[12'(a + 32'(j))] = 8'($urandom_range(1, 255));
          mem[12'(a + 32'(len))] = 8'h00;
        end
        7, 8: begin
          v = 32'd11;
          a = $urandom;
        end
        default: begin
          v = 32'($urandom_range(0, 40));
          if (v == 32'd1 || v == 32'd4 || v == 32'd10 || v == 32'd11) v = 32'd7;
          a = $urandom;
        end
      endcase
      run(v, a);
      chain = ($urandom_range(0, 3) == 0) && i < 39;
      if (!chain) verify("rand");
    end
    do_reset();
    rmode = 2;
    pat.delete();
    syscall_en = 1'b1;
    v0 = 32'd1;
    a0 = -32'sd305;
    for (int n = 0; n < 40 && !char_valid_o; n++) @(negedge clock);
    chk("emit_reached", 32'(char_valid_o), 32'd1);
    do_reset();
    rmode = 1;
    run(32'd11, 32'h37);        verify("after_reset");
    syscall_en = 1'b1;
    v0 = 32'd10;
    a0 = $urandom;
    repeat (4) @(negedge clock);
    syscall_en = 1'b0;
    repeat (3) @(negedge clock);
    chk("halt_set", 32'(halt_o), 32'd1);
    chk("halt_stall", 32'(stall_o), 32'd1);
    chk("halt_no_char", 32'(char_valid_o), 32'd0);
    chk("halt_no_error", 32'(error_o), 32'd0);
    do_reset();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
